// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage control, branch training and IF/ID output bundle
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pc_write;
    logic                  ex_redirect;
    logic [DATA_WIDTH-1:0] ex_redirect_PC;
    logic                  ex_update;
    logic [DATA_WIDTH-1:0] ex_PC;
    logic                  ex_taken;
    logic [DATA_WIDTH-1:0] ex_target;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instruction;
    logic [DATA_WIDTH-1:0] if_PC;
    logic [DATA_WIDTH-1:0] if_pc_plus_4;
    logic [DATA_WIDTH-1:0] if_instruction;
    logic                  if_pred;
    logic [DATA_WIDTH-1:0] if_pred_PC_target;

    modport master (
        input  pc_write, ex_redirect, ex_redirect_PC, ex_update, ex_PC, ex_taken,
               ex_target, imem_instruction,
        output imem_addr, if_PC, if_pc_plus_4, if_instruction, if_pred, if_pred_PC_target
    );

    modport slave (
        output pc_write, ex_redirect, ex_redirect_PC, ex_update, ex_PC, ex_taken,
               ex_target, imem_instruction,
        input  imem_addr, if_PC, if_pc_plus_4, if_instruction, if_pred, if_pred_PC_target
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: program counter plus direct-mapped BTB with 2-bit counters
module fetch_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int INDEX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2;
    localparam logic [DATA_WIDTH-1:0] FOUR = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] pc_plus_4;

    logic                  btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]            btb_ctr    [BTB_ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  if_hit;
    logic                  ex_hit;
    logic                  pred;
    logic [DATA_WIDTH-1:0] pred_target;
    logic [1:0]            ex_ctr;
    logic                  unused_pc_bits;

    // Instructions are word aligned, so the low two PC bits play no part in lookup.
    assign if_idx = pc_q[INDEX_BITS+1:2];
    assign if_tag = pc_q[DATA_WIDTH-1:INDEX_BITS+2];
    assign ex_idx = bus.ex_PC[INDEX_BITS+1:2];
    assign ex_tag = bus.ex_PC[DATA_WIDTH-1:INDEX_BITS+2];
    assign unused_pc_bits = ^{pc_q[1:0], bus.ex_PC[1:0]};

    assign pc_plus_4   = pc_q + FOUR;
    assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred        = if_hit && btb_ctr[if_idx][1];
    assign pred_target = pred ? btb_target[if_idx] : pc_plus_4;

    assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign ex_ctr = btb_ctr[ex_idx];

    assign bus.imem_addr         = pc_q;
    assign bus.if_PC             = pc_q;
    assign bus.if_pc_plus_4      = pc_plus_4;
    assign bus.if_instruction    = bus.imem_instruction;
    assign bus.if_pred           = pred;
    assign bus.if_pred_PC_target = pred_target;

    // A redirect from EX overrides a stall.
    always_comb begin
        pc_next = pred_target;
        if (bus.ex_redirect) begin
            pc_next = bus.ex_redirect_PC;
        end else if (!bus.pc_write) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Training ignores stalls and redirects; lookups see the update one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (bus.ex_update) begin
            if (ex_hit) begin
                if (bus.ex_taken) begin
                    btb_ctr[ex_idx]    <= (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
                    btb_target[ex_idx] <= bus.ex_target;
                end else begin
                    btb_ctr[ex_idx] <= (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
                end
            end else if (bus.ex_taken) begin
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= bus.ex_target;
                btb_ctr[ex_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] IMEM_XOR = 32'hA5A5_0F0F;

    typedef struct {
        logic        pw;
        logic        rd;
        logic [31:0] rpc;
        logic        up;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] etg;
        logic [31:0] xpc;
        logic        xpred;
        logic [31:0] xtgt;
    } row_t;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_instruction = bus.imem_addr ^ IMEM_XOR;

    function automatic row_t mk(input logic pw, input logic rd, input logic [31:0] rpc,
                                input logic up, input logic [31:0] epc, input logic tk,
                                input logic [31:0] etg, input logic [31:0] xpc,
                                input logic xpred, input logic [31:0] xtgt);
        row_t r;
        r.pw = pw; r.rd = rd; r.rpc = rpc; r.up = up; r.epc = epc; r.tk = tk; r.etg = etg;
        r.xpc = xpc; r.xpred = xpred; r.xtgt = xtgt;
        return r;
    endfunction

    task automatic drive(input row_t r);
        bus.pc_write       = r.pw;
        bus.ex_redirect    = r.rd;
        bus.ex_redirect_PC = r.rpc;
        bus.ex_update      = r.up;
        bus.ex_PC          = r.epc;
        bus.ex_taken       = r.tk;
        bus.ex_target      = r.etg;
    endtask

    function automatic exp_t ex(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        exp_t e;
        e.pc = pc; e.pred = pred; e.tgt = tgt;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        sb.push_back(ex(32'h0, 1'b0, 32'h4));
        e = sb.pop_front();
        total++;
        if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
            bus.if_pc_plus_4 !== e.pc + 32'd4 || bus.if_instruction !== (e.pc ^ IMEM_XOR)) begin
            bad++;
            $display("FAIL reset_held got pc=%h pred=%b tgt=%h p4=%h want pc=%h pred=%b tgt=%h",
                     bus.if_PC, bus.if_pred, bus.if_pred_PC_target, bus.if_pc_plus_4, e.pc, e.pred, e.tgt);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        sb.push_back(ex(32'h0, 1'b0, 32'h4));
        e = sb.pop_front();
        total++;
        if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
            bus.imem_addr !== e.pc) begin
            bad++;
            $display("FAIL reset_release got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                     bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
        end
    endtask

    task automatic test_sequential();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h4, 0, 32'h8));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h8, 0, 32'hC));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'h10));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(ex(rows[i].xpc, rows[i].xpred, rows[i].xtgt));
            @(posedge clk); #2;
            e = sb.pop_front();
            total++;
            if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
                bus.if_pc_plus_4 !== e.pc + 32'd4 || bus.if_instruction !== (e.pc ^ IMEM_XOR)) begin
                bad++;
                $display("FAIL sequential[%0d] got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                         i, bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_stall_redirect();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h8,  0, 0, 0, 0, 32'h8,  0, 32'hC));
        rows.push_back(mk(0, 0, 0,      0, 0, 0, 0, 32'h8,  0, 32'hC));
        rows.push_back(mk(0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 32'h44));
        rows.push_back(mk(1, 0, 0,      0, 0, 0, 0, 32'h44, 0, 32'h48));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(ex(rows[i].xpc, rows[i].xpred, rows[i].xtgt));
            @(posedge clk); #2;
            e = sb.pop_front();
            total++;
            if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
                bus.if_pc_plus_4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL stall_redirect[%0d] got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                         i, bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_alloc_hysteresis();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h10, 1, 32'h10, 1, 32'h80, 32'h10, 1, 32'h80));
        rows.push_back(mk(1, 0, 0,      0, 0,      0, 0,      32'h80, 0, 32'h84));
        rows.push_back(mk(1, 1, 32'h10, 1, 32'h10, 0, 0,      32'h10, 0, 32'h14));
        rows.push_back(mk(0, 0, 0,      1, 32'h10, 1, 32'h80, 32'h10, 1, 32'h80));
        rows.push_back(mk(0, 0, 0,      1, 32'h10, 1, 32'h80, 32'h10, 1, 32'h80));
        rows.push_back(mk(0, 0, 0,      1, 32'h10, 1, 32'h80, 32'h10, 1, 32'h80));
        rows.push_back(mk(0, 0, 0,      1, 32'h10, 0, 0,      32'h10, 1, 32'h80));
        rows.push_back(mk(0, 0, 0,      1, 32'h10, 0, 0,      32'h10, 0, 32'h14));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(ex(rows[i].xpc, rows[i].xpred, rows[i].xtgt));
            @(posedge clk); #2;
            e = sb.pop_front();
            total++;
            if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
                bus.if_pc_plus_4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL alloc_hyst[%0d] got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                         i, bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_alias_same_cycle();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h10, 1, 32'h50, 1, 32'h200, 32'h10,  0, 32'h14));
        rows.push_back(mk(1, 1, 32'h50, 0, 0,      0, 0,       32'h50,  1, 32'h200));
        rows.push_back(mk(1, 0, 0,      1, 32'h50, 0, 0,       32'h200, 0, 32'h204));
        rows.push_back(mk(1, 1, 32'h50, 0, 0,      0, 0,       32'h50,  0, 32'h54));
        foreach (rows[i]) begin
            drive(rows[i]);
            if (i == 2) begin
                // training index 4 while fetching 0x50 must not alter this cycle's prediction
                #1;
                sb.push_back(ex(32'h50, 1'b1, 32'h200));
                e = sb.pop_front();
                total++;
                if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt) begin
                    bad++;
                    $display("FAIL same_cycle_lookup got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                             bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
                end
            end
            sb.push_back(ex(rows[i].xpc, rows[i].xpred, rows[i].xtgt));
            @(posedge clk); #2;
            e = sb.pop_front();
            total++;
            if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
                bus.if_pc_plus_4 !== e.pc + 32'd4) begin
                bad++;
                $display("FAIL alias[%0d] got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                         i, bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_async_reset_wrap();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h10, 1, 32'h10, 1, 32'h80, 32'h10, 1, 32'h80));
        rows.push_back(mk(1, 0, 0,      0, 0,      0, 0,      32'h80, 0, 32'h84));
        rows.push_back(mk(1, 0, 0,      0, 0,      0, 0,      32'h4,  0, 32'h8));
        rows.push_back(mk(1, 1, 32'h10, 0, 0,      0, 0,      32'h10, 0, 32'h14));
        rows.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,    32'hFFFF_FFFC, 0, 32'h0));
        rows.push_back(mk(1, 0, 0,      0, 0,      0, 0,      32'h0,  0, 32'h4));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(ex(rows[i].xpc, rows[i].xpred, rows[i].xtgt));
            @(posedge clk); #2;
            e = sb.pop_front();
            total++;
            if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt ||
                bus.if_pc_plus_4 !== e.pc + 32'd4 || bus.if_instruction !== (e.pc ^ IMEM_XOR)) begin
                bad++;
                $display("FAIL async_wrap[%0d] got pc=%h pred=%b tgt=%h p4=%h want pc=%h pred=%b tgt=%h",
                         i, bus.if_PC, bus.if_pred, bus.if_pred_PC_target, bus.if_pc_plus_4,
                         e.pc, e.pred, e.tgt);
            end
            if (i == 1) begin
                // pending training and the PC are both dropped by a pulse between edges
                drive(mk(1, 0, 0, 1, 32'h10, 1, 32'h300, 0, 0, 0));
                reset = 1'b1;
                #1;
                sb.push_back(ex(32'h0, 1'b0, 32'h4));
                e = sb.pop_front();
                total++;
                if (bus.if_PC !== e.pc || bus.if_pred !== e.pred || bus.if_pred_PC_target !== e.tgt) begin
                    bad++;
                    $display("FAIL async_reset got pc=%h pred=%b tgt=%h want pc=%h pred=%b tgt=%h",
                             bus.if_PC, bus.if_pred, bus.if_pred_PC_target, e.pc, e.pred, e.tgt);
                end
                reset = 1'b0;
                bus.ex_update = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_alloc_hysteresis();
        test_alias_same_cycle();
        test_async_reset_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage. It owns the program counter and a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, and it drives the IF-side inputs of the IF/ID pipeline register: PC, PC+4, instruction and branch prediction. It takes stall and redirect control from the hazard and branch-resolution logic. Branch outcomes resolved in EX train the predictor.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, instruction and targets
- BTB_ENTRIES, 16, BTB depth; power of two, at least 2; INDEX_BITS = log2(BTB_ENTRIES)
- RESET_PC, 32'h0, PC value loaded on reset

Ports:
- clk, in, 1, clock; all state updates on rising edge
- reset, in, 1, asynchronous, active-high; clears PC and BTB
- pc_write, in, 1, 1 = advance PC; 0 = hold PC (stall, paired with ifid_write)
- ex_redirect, in, 1, mispredict or flush; next PC = ex_redirect_PC
- ex_redirect_PC, in, DATA_WIDTH, correct next PC from EX
- ex_update, in, 1, a conditional branch resolved this cycle; train BTB
- ex_PC, in, DATA_WIDTH, PC of the resolved branch
- ex_taken, in, 1, resolved direction
- ex_target, in, DATA_WIDTH, resolved taken target
- imem_addr, out, DATA_WIDTH, instruction memory address; equals if_PC
- imem_instruction, in, DATA_WIDTH, combinational imem read data
- if_PC, out, DATA_WIDTH, current fetch PC (registered)
- if_pc_plus_4, out, DATA_WIDTH, if_PC + 4, modulo 2^DATA_WIDTH
- if_instruction, out, DATA_WIDTH, passthrough of imem_instruction
- if_pred, out, 1, predicted taken
- if_pred_PC_target, out, DATA_WIDTH, predicted next PC

## Operation
- **BTB entry fields:** valid, tag, target, ctr[1:0].
- **Address split:** index = PC[INDEX_BITS+1:2]; tag = PC[DATA_WIDTH-1:INDEX_BITS+2]. PC[1:0] is ignored.
- **Lookup (combinational on if_PC):** hit = valid && tag match. if_pred = hit && ctr[1]. if_pred_PC_target = if_pred ? entry.target : if_pc_plus_4.
- **Next-PC priority, highest first:**
  1. reset: RESET_PC.
  2. ex_redirect: ex_redirect_PC. This applies even when pc_write = 0.
  3. pc_write = 0: hold.
  4. Otherwise: if_pred_PC_target.
- **Training on ex_update, at the index of ex_PC:**
  - Hit, taken: ctr = min(ctr+1, 3); target = ex_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate the entry with valid = 1, tag, target = ex_target, ctr = 2'b10. Any aliasing entry is replaced.
  - Miss, not taken: no change.
- Training is independent of pc_write and ex_redirect. It happens during stalls and redirects.
- The BTB is written only on the clock edge. A same-cycle lookup of the entry being trained sees the old contents.

## Timing
- **Reset values (asynchronous):**
  - if_PC = RESET_PC; if_pc_plus_4 = RESET_PC + 4.
  - All valid = 0, all ctr = 2'b01, tags and targets = 0.
  - Therefore if_pred = 0 and if_pred_PC_target = RESET_PC + 4.
  - if_instruction follows imem.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. Any in-flight training is discarded.
- The first rising edge after reset deasserts advances the PC normally.
- All outputs except if_PC are combinational from if_PC, BTB state and imem_instruction. There is zero-cycle latency within the fetch cycle.
- A redirect takes effect on the edge where ex_redirect = 1. if_PC shows ex_redirect_PC in the following cycle.
- A training write on edge N is visible to a lookup in cycle N+1.
- PC arithmetic wraps: 32'hFFFFFFFC + 4 = 32'h0.

## Test plan
Defaults for all scenarios: BTB_ENTRIES = 16, RESET_PC = 0.

1. **Sequential fetch:** release reset and hold pc_write = 1 for 4 cycles. Required: if_PC = 0, 4, 8, C; if_pred = 0; if_pred_PC_target = if_PC + 4 in every cycle.
2. **Stall and redirect:**
   - At if_PC = 8, drive pc_write = 0 for 2 cycles. Required: if_PC holds 8.
   - During the stall, drive ex_redirect = 1 with ex_redirect_PC = 0x40. Required: the next cycle shows if_PC = 0x40.
3. **Allocation:** drive ex_update with ex_PC = 0x10, ex_taken = 1, ex_target = 0x80. Later fetch PC 0x10. Required: if_pred = 1, if_pred_PC_target = 0x80, and the next if_PC = 0x80.
4. **Hysteresis and saturation, on the 0x10 entry (ctr = 10):**
   - One not-taken update. Required: ctr = 01; a fetch of 0x10 gives if_pred = 0 and target 0x14.
   - Three taken updates. Required: ctr = 11 and saturated; if_pred = 1.
5. **Aliasing and same-cycle update:**
   - Taken update with ex_PC = 0x50, ex_target = 0x200 (same index 4, different tag). Required: the entry is replaced; fetching 0x10 gives if_pred = 0; fetching 0x50 gives if_pred = 1 with target 0x200.
   - Train index 4 while if_PC = 0x50. Required: that cycle's prediction uses the old entry.
6. **Asynchronous reset mid-run:**
   - With if_PC = 0x80 and a trained BTB, pulse reset between clock edges. Required: if_PC = 0 before the next edge.
   - After release, fetch 0x10. Required: if_pred = 0.
   - At PC 0xFFFFFFFC. Required: if_pc_plus_4 = 0.
